// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   SEG_OFF         - segment pattern with every segment and dp dark (active-low)
//   MAX_DIGITS      - widest digit count the helpers support
//   nibble_t        - one hex digit
//   anode_onehot_n  - active-low one-hot anode pattern for a digit index
package sev_seg_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    typedef logic [3:0] nibble_t;

    // Bit 'idx' is driven low when it addresses a real digit (idx < n);
    // all other bits, including unused upper bits, stay high (dark).
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input int idx, input int n);
        logic [MAX_DIGITS-1:0] r;
        r = '1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i == idx) && (i < n)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_seven_logic.sv
// Hex nibble to seven-segment decoder, active-low outputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
//
// Ports:
//   hex   - hex digit 0..F
//   seg_n - segments {g,f,e,d,c,b,a}, 0 = segment lit
module seg_seven_logic
    import sev_seg_pkg::*;
(
    input  nibble_t    hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7F;
        unique case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;  // lowercase b
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;  // lowercase d
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0E;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed N-digit common-anode seven-segment driver with double-buffered frames.
// Latency: outputs registered, one cycle behind scan state; load-to-display <= NUM_DIGITS*REFRESH_CYCLES+1.
// Backpressure: none; load always accepted, a newer load overwrites an uncommitted pending frame.
//
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   enable           - scan enable; low forces the display dark and parks the scan at digit 0
//   load             - one-cycle strobe capturing data_in/dp_in/blank_in into the pending buffer
//   data_in          - digit i hex value at [4i+3:4i]
//   dp_in, blank_in  - per-digit decimal point (1 = lit) and blank (1 = dark)
//   segment          - active-low {dp, g..a}
//   anode            - active-low digit select
//   frame_tick       - one-cycle pulse after each frame boundary
//   pending          - a captured frame is waiting to be committed
module sev_seg_mux
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position: cycle within the digit slot, and the digit being shown.
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Pending buffer: written by load, committed to the display buffer only
    // at a frame boundary (or at once while dark) so a frame never tears.
    nibble_t [NUM_DIGITS-1:0] pend_data;
    logic    [NUM_DIGITS-1:0] pend_dp;
    logic    [NUM_DIGITS-1:0] pend_blank;
    logic                     pend_valid;

    // Display buffer: the frame currently being scanned.
    nibble_t [NUM_DIGITS-1:0] disp_data;
    logic    [NUM_DIGITS-1:0] disp_dp;
    logic    [NUM_DIGITS-1:0] disp_blank;

    logic                  slot_end;
    logic                  frame_end;
    logic                  in_guard;
    logic                  lit;
    logic                  commit;
    nibble_t               cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            cur_seg_n;
    logic [MAX_DIGITS-1:0] onehot_full;
    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [7:0]            segment_nxt;

    always_comb begin
        slot_end    = (cnt == CNT_LAST);
        frame_end   = slot_end && (idx == IDX_LAST);
        // Widened compare keeps GUARD_CYCLES == 0 well defined (never in guard).
        in_guard    = (32'(cnt) < GUARD_CYCLES);

        cur_nibble  = disp_data[idx];
        cur_dp      = disp_dp[idx];
        cur_blank   = disp_blank[idx];

        lit         = enable && !in_guard && !cur_blank;
        onehot_full = anode_onehot_n(int'(idx), NUM_DIGITS);

        anode_nxt   = '1;
        segment_nxt = SEG_OFF;
        if (lit) begin
            anode_nxt   = onehot_full[NUM_DIGITS-1:0];
            segment_nxt = {~cur_dp, cur_seg_n};
        end

        // While dark nothing can tear, so a pending frame commits immediately.
        commit = enable ? (frame_end && pend_valid) : pend_valid;
    end

    // Single decoder shared by all digits, fed with the currently scanned nibble.
    seg_seven_logic u_dec (
        .hex   (cur_nibble),
        .seg_n (cur_seg_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            anode      <= '1;
            segment    <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            // Scan counter: parked at slot 0 while disabled so re-enable
            // starts cleanly with a full guard interval on digit 0.
            if (!enable) begin
                cnt <= '0;
                idx <= '0;
            end else if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (commit) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end

            // Placed after the commit so a load on the boundary cycle wins
            // pend_valid: the old frame moves to display, the new one waits.
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end

            anode      <= anode_nxt;
            segment    <= segment_nxt;
            frame_tick <= enable && frame_end;
        end
    end

    assign pending = pend_valid;

endmodule

// File: tb/tb_sev_seg_mux.sv
module tb_sev_seg_mux;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = N * R;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame_tick;
    logic        pending;

    always #5 clk = ~clk;

    sev_seg_mux #(
        .NUM_DIGITS     (N),
        .REFRESH_CYCLES (R),
        .GUARD_CYCLES   (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .segment    (segment),
        .anode      (anode),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Lit segments of each hex glyph, by letter.
    string lit_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Reference model: scan position within the frame plus the two frame buffers.
    int          m_pos;
    logic [15:0] m_disp_data, m_pend_data;
    logic [3:0]  m_disp_dp, m_pend_dp, m_disp_blank, m_pend_blank;
    logic        m_pend_valid;
    logic [3:0]  exp_anode;
    logic [7:0]  exp_seg;
    logic        exp_tick;
    logic        exp_pend;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] g;
        string s;
        g = 7'h7F;
        s = lit_segs[v];
        for (int i = 0; i < s.len(); i++) begin
            g[int'(s[i]) - 97] = 1'b0;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int   slot, phase, digit;
        logic boundary, transfer, lit;
        if (!rst_n) begin
            m_pos = 0;
            m_disp_data = '0; m_disp_dp = '0; m_disp_blank = '0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
            m_pend_valid = 1'b0;
            exp_anode = 4'hF; exp_seg = 8'hFF; exp_tick = 1'b0; exp_pend = 1'b0;
            return;
        end
        slot  = (m_pos / R) % N;
        phase = m_pos % R;
        if (enable) begin
            digit     = int'((m_disp_data >> (4 * slot)) & 16'hF);
            lit       = (phase >= G) && !m_disp_blank[slot];
            exp_anode = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg   = lit ? {~m_disp_dp[slot], glyph(digit)} : 8'hFF;
            boundary  = (m_pos == FR - 1);
            exp_tick  = boundary;
            transfer  = boundary && m_pend_valid;
            m_pos     = (m_pos + 1) % FR;
        end else begin
            exp_anode = 4'hF;
            exp_seg   = 8'hFF;
            exp_tick  = 1'b0;
            transfer  = m_pend_valid;
            m_pos     = 0;
        end
        if (transfer) begin
            m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
            m_pend_valid = 1'b0;
        end
        if (load) begin
            m_pend_data = data_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
            m_pend_valid = 1'b1;
        end
        exp_pend = m_pend_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("anode", anode, exp_anode);
        chk("segment", segment, exp_seg);
        chk("frame_tick", frame_tick, exp_tick);
        chk("pending", pending, exp_pend);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        load = 1'b1; data_in = d; dp_in = dp; blank_in = bl;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0;
        data_in = '0; dp_in = '0; blank_in = '0;

        // Reset held with enable high.
        run(3);
        chk("reset_anode", anode, 4'hF);
        chk("reset_segment", segment, 8'hFF);
        chk("reset_pending", pending, 1'b0);

        // Basic frame loaded while dark, then scanned.
        rst_n = 1'b1; enable = 1'b0;
        do_load(16'h1234, 4'b0001, 4'b0000);
        chk("load_pending", pending, 1'b1);
        run(1);
        chk("dark_commit", pending, 1'b0);
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2)  chk("guard_dark", anode, 4'hF);
            if (k == 3)  chk("d0_anode", anode, 4'b1110);
            if (k == 3)  chk("d0_seg", segment, 8'h19);
            if (k == 8)  chk("d0_last_lit", anode, 4'b1110);
            if (k == 9)  chk("d1_guard", anode, 4'hF);
            if (k == 11) chk("d1_anode", anode, 4'b1101);
            if (k == 32) chk("first_tick", frame_tick, 1'b1);
        end

        // Double buffering: mid-frame load waits for the boundary.
        do_load(16'hABCD, 4'b1010, 4'b0000);
        run(60);

        // Boundary collision: 9999 pending, 5555 loaded on the boundary cycle.
        do_load(16'h9999, 4'b0000, 4'b0000);
        for (int i = 0; i < FR && m_pos != FR - 1; i++) tick();
        chk("collide_pending_before", pending, 1'b1);
        do_load(16'h5555, 4'b1111, 4'b0000);
        chk("collide_tick", frame_tick, 1'b1);
        chk("collide_pending_after", pending, 1'b1);
        run(70);

        // Blanking of digit 2.
        do_load(16'h8888, 4'b1111, 4'b0100);
        run(40);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("blank_anode2", anode[2], 1'b1);
        end

        // Enable dropped mid-slot, then restored.
        run(5);
        enable = 1'b0;
        tick();
        chk("drop_dark", anode, 4'hF);
        run(3);
        enable = 1'b1;
        tick();
        chk("reen_guard0", anode, 4'hF);
        tick();
        chk("reen_guard1", anode, 4'hF);
        tick();
        chk("reen_d0", anode, 4'b1110);
        run(40);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(299) != 0);
            if ($urandom_range(59) == 0) enable = ~enable;
            load = ($urandom_range(15) == 0);
            data_in = 16'($urandom);
            dp_in = 4'($urandom);
            blank_in = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            tick();
        end
        rst_n = 1'b1; load = 1'b0; enable = 1'b1;
        run(2 * FR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
